// File: rtl/pingpong_skew_input_buffer.sv
// Ping-pong column staging buffer for the MATU systolic array: one bank loads while the other
// drains, with optional diagonal skew (row r delayed r steps) and downstream back-pressure.

module pingpong_skew_lane #(
    parameter int R  = 0,
    parameter int LW = 4,
    parameter int TW = 4,
    parameter int AW = 4
) (
    input  logic [TW-1:0] t,
    input  logic          skew,
    input  logic [LW-1:0] len,
    output logic          vld,
    output logic [AW-1:0] col
);
    logic [TW-1:0] ofs;
    logic [TW-1:0] c;

    always_comb begin
        ofs = skew ? TW'(R) : '0;
        c   = t - ofs;
        // c wraps when t < ofs, so the lower bound is checked on t directly
        vld = (t >= ofs) && (c < TW'(len));
        col = AW'(c);
    end
endmodule

module pingpong_skew_input_buffer #(
    parameter int ROWS  = 3,
    parameter int DEPTH = 9,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [$clog2(DEPTH+1)-1:0] i_cfg_len,
    input  logic                     i_pre_valid,
    output logic                     o_pre_ready,
    input  logic [ROWS*WIDTH-1:0]    i_data,
    output logic                     o_load_done,
    input  logic                     i_skew_en,
    input  logic                     i_start,
    output logic                     o_busy,
    input  logic                     i_post_ready,
    output logic [ROWS-1:0]          o_valid,
    output logic [ROWS*WIDTH-1:0]    o_data,
    output logic                     o_drain_done
);
    localparam int LW = $clog2(DEPTH+1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(DEPTH+ROWS);

    typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL, B_DRAIN} bank_st_e;

    bank_st_e              bank_st  [2];
    bank_st_e              bank_nxt [2];
    logic [LW-1:0]         bank_len [2];
    logic [ROWS*WIDTH-1:0] mem      [2][DEPTH];

    logic          wr_sel, rd_sel;
    logic [LW-1:0] wr_cnt;
    logic          busy, skew_q, load_done_q;
    logic [TW-1:0] t_q;

    logic [LW-1:0] cfg_len_eff, cur_len, rd_len;
    logic [TW-1:0] steps, nxt_t;
    logic          load_acc, load_last, start_acc, drain_last, adv, nxt_skew;

    logic [ROWS-1:0]          lane_vld;
    logic [ROWS-1:0][AW-1:0]  lane_col;
    logic [ROWS*WIDTH-1:0]    lane_data;

    always_comb begin
        cfg_len_eff = (i_cfg_len == '0 || i_cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : i_cfg_len;
        o_pre_ready = (bank_st[wr_sel] == B_EMPTY) || (bank_st[wr_sel] == B_FILL);
        load_acc    = i_pre_valid && o_pre_ready;
        // length is latched on the first beat, so the first beat itself uses the live value
        cur_len     = (bank_st[wr_sel] == B_EMPTY) ? cfg_len_eff : bank_len[wr_sel];
        load_last   = load_acc && (wr_cnt == cur_len - LW'(1));
        start_acc   = i_start && !busy && (bank_st[rd_sel] == B_FULL);
        rd_len      = bank_len[rd_sel];
        steps       = TW'(rd_len) + (skew_q ? TW'(ROWS-1) : TW'(0));
        drain_last  = busy && i_post_ready && (t_q == steps - TW'(1));
        adv         = start_acc || (busy && i_post_ready && !drain_last);
        nxt_t       = start_acc ? '0 : t_q + TW'(1);
        nxt_skew    = start_acc ? i_skew_en : skew_q;
    end

    // bank state next-state
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_nxt[b] = bank_st[b];
            if (load_acc && wr_sel == 1'(b))
                bank_nxt[b] = load_last ? B_FULL : B_FILL;
            if (start_acc && rd_sel == 1'(b))
                bank_nxt[b] = B_DRAIN;
            if (drain_last && rd_sel == 1'(b))
                bank_nxt[b] = B_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_st[b]  <= B_EMPTY;
                bank_len[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++)
                bank_st[b] <= bank_nxt[b];
            if (load_acc && bank_st[wr_sel] == B_EMPTY)
                bank_len[wr_sel] <= cfg_len_eff;
        end
    end

    always_ff @(posedge i_clk) begin
        if (load_acc)
            mem[wr_sel][AW'(wr_cnt)] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            wr_cnt      <= '0;
            busy        <= 1'b0;
            skew_q      <= 1'b0;
            t_q         <= '0;
            load_done_q <= 1'b0;
        end else begin
            load_done_q <= load_last;
            if (load_acc)
                wr_cnt <= load_last ? '0 : wr_cnt + LW'(1);
            if (load_last)
                wr_sel <= ~wr_sel;
            if (start_acc) begin
                busy   <= 1'b1;
                skew_q <= i_skew_en;
            end else if (drain_last) begin
                busy   <= 1'b0;
                rd_sel <= ~rd_sel;
            end
            if (adv)
                t_q <= nxt_t;
        end
    end

    // per-row column selection for the step about to be registered
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        pingpong_skew_lane #(.R(r), .LW(LW), .TW(TW), .AW(AW)) u_lane (
            .t    (nxt_t),
            .skew (nxt_skew),
            .len  (rd_len),
            .vld  (lane_vld[r]),
            .col  (lane_col[r])
        );
        assign lane_data[r*WIDTH +: WIDTH] =
            lane_vld[r] ? mem[rd_sel][lane_col[r]][r*WIDTH +: WIDTH] : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || drain_last) begin
            o_valid <= '0;
            o_data  <= '0;
        end else if (adv) begin
            o_valid <= lane_vld;
            o_data  <= lane_data;
        end
    end

    assign o_busy       = busy;
    assign o_load_done  = load_done_q;
    assign o_drain_done = drain_last;
endmodule

// File: tb/tb_pingpong_skew_input_buffer.sv
// Scoreboarded bench for pingpong_skew_input_buffer: tile-level reference model predicts
// handshakes and per-step drain output; a separate monitor compares consumed drain steps.

module tb_pingpong_skew_input_buffer;
    localparam int ROWS  = 3;
    localparam int DEPTH = 9;
    localparam int WIDTH = 8;
    localparam int LW    = $clog2(DEPTH+1);
    localparam int DW    = ROWS*WIDTH;

    logic            clk = 1'b0;
    logic            i_rst = 1'b1;
    logic [LW-1:0]   i_cfg_len = '0;
    logic            i_pre_valid = 1'b0;
    logic            o_pre_ready;
    logic [DW-1:0]   i_data = '0;
    logic            o_load_done;
    logic            i_skew_en = 1'b0;
    logic            i_start = 1'b0;
    logic            o_busy;
    logic            i_post_ready = 1'b1;
    logic [ROWS-1:0] o_valid;
    logic [DW-1:0]   o_data;
    logic            o_drain_done;

    pingpong_skew_input_buffer #(.ROWS(ROWS), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_cfg_len(i_cfg_len), .i_pre_valid(i_pre_valid),
        .o_pre_ready(o_pre_ready), .i_data(i_data), .o_load_done(o_load_done),
        .i_skew_en(i_skew_en), .i_start(i_start), .o_busy(o_busy),
        .i_post_ready(i_post_ready), .o_valid(o_valid), .o_data(o_data),
        .o_drain_done(o_drain_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            len;
        logic [DW-1:0] cols [DEPTH];
    } tile_t;

    typedef struct {
        logic [ROWS-1:0] v;
        logic [DW-1:0]   d;
        bit              last;
    } step_t;

    int checks = 0;
    int failures = 0;

    tile_t full_q [$];
    step_t exp_q  [$];
    tile_t cur;
    int    fill_cnt, fill_len, left;
    bit    m_busy, m_ld_pend, acc_l, mon_en;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clamp_len(int c);
        return (c == 0 || c > DEPTH) ? DEPTH : c;
    endfunction

    task automatic model_reset();
        full_q.delete();
        exp_q.delete();
        fill_cnt = 0; fill_len = 0; left = 0;
        m_busy = 0; m_ld_pend = 0; acc_l = 0;
    endtask

    task automatic push_drain(tile_t tl, bit sk);
        int s;
        step_t st;
        s = tl.len + (sk ? ROWS-1 : 0);
        for (int t = 0; t < s; t++) begin
            st.v = '0; st.d = '0; st.last = (t == s-1);
            for (int r = 0; r < ROWS; r++) begin
                int c;
                c = t - (sk ? r : 0);
                if (c >= 0 && c < tl.len) begin
                    st.v[r] = 1'b1;
                    st.d[r*WIDTH +: WIDTH] = tl.cols[c][r*WIDTH +: WIDTH];
                end
            end
            exp_q.push_back(st);
        end
        left = s;
    endtask

    // Evaluated mid-cycle with inputs stable; updates the model to the post-edge state.
    task automatic model_eval();
        bit m_ready, acc_s, cons;
        m_ready = (full_q.size() + (m_busy ? 1 : 0)) < 2;
        chk("pre_ready", 64'(o_pre_ready), 64'(m_ready));
        chk("busy", 64'(o_busy), 64'(m_busy));
        chk("load_done", 64'(o_load_done), 64'(m_ld_pend));
        if (i_rst) begin
            model_reset();
            return;
        end
        acc_l = i_pre_valid && m_ready;
        acc_s = i_start && !m_busy && full_q.size() > 0;
        cons  = m_busy && i_post_ready;
        m_ld_pend = 0;
        if (cons) begin
            left--;
            if (left == 0) m_busy = 0;
        end
        if (acc_s) begin
            push_drain(full_q.pop_front(), i_skew_en);
            m_busy = 1;
        end
        if (acc_l) begin
            if (fill_cnt == 0) fill_len = clamp_len(int'(i_cfg_len));
            cur.cols[fill_cnt] = i_data;
            fill_cnt++;
            if (fill_cnt == fill_len) begin
                cur.len = fill_len;
                full_q.push_back(cur);
                fill_cnt = 0;
                m_ld_pend = 1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a drain step is consumed when it is shown with i_post_ready high.
    always @(negedge clk) begin
        if (mon_en && !i_rst) begin
            if (|o_valid) begin
                if (!i_post_ready) begin
                    chk("drain_done_stalled", 64'(o_drain_done), 64'(0));
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_step", 64'(o_valid), 64'(0));
                end else begin
                    step_t e;
                    e = exp_q.pop_front();
                    chk("step_valid", 64'(o_valid), 64'(e.v));
                    chk("step_data", 64'(o_data), 64'(e.d));
                    chk("drain_done", 64'(o_drain_done), 64'(e.last));
                end
            end else begin
                chk("idle_data", 64'(o_data), 64'(0));
                chk("idle_drain_done", 64'(o_drain_done), 64'(0));
            end
        end
    end

    task automatic load_tile(int cfg, int n, int base);
        int g = 0;
        i_cfg_len = LW'(cfg);
        for (int k = 0; k < n; ) begin
            i_pre_valid = 1'b1;
            for (int r = 0; r < ROWS; r++)
                i_data[r*WIDTH +: WIDTH] = WIDTH'(base + ROWS*k + r + 1);
            tick();
            if (acc_l) k++;
            if (++g > 200) begin
                chk("load_timeout", 64'(k), 64'(n));
                break;
            end
        end
        i_pre_valid = 1'b0;
    endtask

    // Issue a start, then count busy cycles until the drain ends; optional 1,0,0,1 stall.
    task automatic run_drain(bit sk, int exp_cycles, bit stall);
        int n = 0;
        i_start = 1'b1; i_skew_en = sk; i_post_ready = 1'b1;
        tick();
        i_start = 1'b0;
        while (o_busy === 1'b1 && n < 100) begin
            i_post_ready = (stall && (n == 1 || n == 2)) ? 1'b0 : 1'b1;
            n++;
            tick();
        end
        i_post_ready = 1'b1;
        chk("drain_cycles", 64'(n), 64'(exp_cycles));
    endtask

    initial begin
        model_reset();
        mon_en = 0;
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b0;
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_data", 64'(o_data), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_pre_ready", 64'(o_pre_ready), 64'(1));
        chk("rst_load_done", 64'(o_load_done), 64'(0));
        chk("rst_drain_done", 64'(o_drain_done), 64'(0));
        mon_en = 1;

        // T1 / T2: skewed then aligned drain of the 1..9 tile
        load_tile(3, 3, 0);
        run_drain(1'b1, 5, 1'b0);
        load_tile(3, 3, 0);
        run_drain(1'b0, 3, 1'b0);

        // T3: load B while A drains
        load_tile(4, 4, 20);
        i_start = 1'b1; i_skew_en = 1'b1;
        tick();
        i_start = 1'b0;
        load_tile(2, 2, 60);
        for (int g = 0; g < 50 && o_busy === 1'b1; g++) tick();
        run_drain(1'b1, 4, 1'b0);

        // T4: both banks full -> loads stall
        load_tile(5, 5, 90);
        load_tile(1, 1, 120);
        chk("both_full_ready", 64'(o_pre_ready), 64'(0));
        i_pre_valid = 1'b1; tick(); tick(); i_pre_valid = 1'b0;
        run_drain(1'b0, 5, 1'b0);
        chk("ready_after_drain", 64'(o_pre_ready), 64'(1));
        run_drain(1'b1, 3, 1'b0);

        // T5: back-pressure mid-drain
        load_tile(3, 3, 0);
        run_drain(1'b1, 7, 1'b1);

        // T6: start with nothing full, len 0 -> DEPTH, reset mid-drain
        i_start = 1'b1; tick(); tick(); i_start = 1'b0;
        chk("idle_start_ignored", 64'(o_busy), 64'(0));
        load_tile(0, DEPTH, 40);
        chk("len0_full_done", 64'(full_q.size()), 64'(1));
        i_start = 1'b1; i_skew_en = 1'b1; tick(); i_start = 1'b0;
        tick(); tick();
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        chk("rst2_valid", 64'(o_valid), 64'(0));
        chk("rst2_data", 64'(o_data), 64'(0));
        chk("rst2_busy", 64'(o_busy), 64'(0));
        chk("rst2_pre_ready", 64'(o_pre_ready), 64'(1));

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            i_pre_valid  = 1'($urandom_range(0, 1));
            i_data       = DW'($urandom);
            i_cfg_len    = LW'($urandom_range(0, 15));
            i_start      = ($urandom_range(0, 3) == 0);
            i_skew_en    = 1'($urandom_range(0, 1));
            i_post_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        i_pre_valid = 1'b0; i_start = 1'b0; i_post_ready = 1'b1;
        for (int g = 0; g < 100 && (m_busy || o_busy === 1'b1); g++) tick();
        tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
